// File: rtl/tinker_pkg.sv
// Shared Tinker front-end types and constants: reset PC, fetch stride and the
// default {pc, instr} queue entry layout.
package tinker_pkg;

  localparam int          TINKER_ADDR_W      = 64;
  localparam int          TINKER_INSTR_W     = 32;
  localparam logic [63:0] TINKER_RESET_PC    = 64'h2000;
  localparam int          TINKER_INSTR_BYTES = 4;

  typedef struct packed {
    logic [TINKER_ADDR_W-1:0]  pc;
    logic [TINKER_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with single-cycle flush.
// Flush and reset both empty the queue; flush wins over a same-cycle push/pop.
module fetch_fifo
  import tinker_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: pipelined in-order reads, credit-limited issue,
// branch flush with in-flight drop. FETCH_QUEUE_PERF_EN adds perf counters.
module fetch_queue
  import tinker_pkg::*;
#(
  parameter int                ADDR_W          = TINKER_ADDR_W,
  parameter int                INSTR_W         = TINKER_INSTR_W,
  parameter int                INSTR_BYTES     = TINKER_INSTR_BYTES,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = TINKER_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hlt,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  branch_pc,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ADDR_W-1:0]  req_addr,
  input  logic               resp_valid,
  input  logic [INSTR_W-1:0] resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]        perf_flushes,
  output logic [31:0]        perf_dropped,
  output logic [31:0]        perf_empty_cycles
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] branch_tgt;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              req_fire;
  logic              dropping;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head;

  assign branch_tgt = {branch_pc[ADDR_W-1:2], 2'b00};

  // Credit rule: every response already in flight owns a queue slot.
  assign req_valid = !reset && !hlt && !branch
                   && (int'(outstanding) < MAX_OUTSTANDING)
                   && (int'(count) + int'(outstanding) < DEPTH);
  assign req_addr  = fetch_pc;
  assign req_fire  = req_valid && req_ready;

  // A response arriving in the flush cycle belongs to the old stream.
  assign dropping   = resp_valid && (branch || drop_cnt != '0);
  assign push       = resp_valid && !dropping;
  assign push_entry = '{pc: resp_pc, instr: resp_data};

  assign instr_valid = !reset && !empty;
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;
  assign busy        = (outstanding != '0) || (drop_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (branch)        fetch_pc <= branch_tgt;
      else if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);

      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(resp_valid);

      if (branch)        drop_cnt <= outstanding - OUT_W'(resp_valid);
      else if (dropping) drop_cnt <= drop_cnt - OUT_W'(1);

      if (branch)    resp_pc <= branch_tgt;
      else if (push) resp_pc <= resp_pc + ADDR_W'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (branch),
    .wr_data (push_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flushes      <= '0;
      perf_dropped      <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (branch && perf_flushes != '1)   perf_flushes <= perf_flushes + 32'd1;
      if (dropping && perf_dropped != '1) perf_dropped <= perf_dropped + 32'd1;
      if (!instr_valid && !hlt && perf_empty_cycles != '1)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table with a 1-cycle memory
// model, plus a wrap-around RESET_PC instance driven by hand.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, hlt, branch, req_ready, resp_valid, instr_ready;
  logic [63:0] branch_pc;
  logic [31:0] resp_data;
  logic        req_valid, instr_valid, busy;
  logic [63:0] req_addr, instr_pc;
  logic [31:0] instr_out;

  logic        w_reset, w_req_ready, w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_req_valid, w_instr_valid, w_busy;
  logic [63:0] w_req_addr, w_instr_pc;
  logic [31:0] w_instr_out;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_flushes, perf_dropped, perf_empty_cycles;
  logic [31:0] w_perf_flushes, w_perf_dropped, w_perf_empty_cycles;
`endif

  fetch_queue dut (
    .clk(clk), .reset(reset), .hlt(hlt), .branch(branch), .branch_pc(branch_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .busy(busy)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_flushes(perf_flushes), .perf_dropped(perf_dropped),
    .perf_empty_cycles(perf_empty_cycles)
`endif
  );

  fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .hlt(1'b0), .branch(1'b0), .branch_pc(64'h0),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
    .resp_valid(w_resp_valid), .resp_data(w_resp_data),
    .instr_valid(w_instr_valid), .instr_ready(1'b0),
    .instr_out(w_instr_out), .instr_pc(w_instr_pc), .busy(w_busy)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_flushes(w_perf_flushes), .perf_dropped(w_perf_dropped),
    .perf_empty_cycles(w_perf_empty_cycles)
`endif
  );

  typedef struct {
    bit          rst, hlt, br;
    logic [63:0] bpc;
    bit          rr, ir, rsp;
    bit          e_rv;
    logic [63:0] e_addr;
    bit          e_iv;
    logic [63:0] e_pc;
    bit          e_busy;
  } vec_t;

  vec_t        vq[$];
  logic [63:0] pend[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic void v(input bit rst, hl, br, input logic [63:0] bpc,
                            input bit rr, ir, rsp, input bit rv,
                            input logic [63:0] addr, input bit iv,
                            input logic [63:0] pc, input bit bsy);
    vec_t t;
    t.rst = rst; t.hlt = hl; t.br = br; t.bpc = bpc;
    t.rr = rr; t.ir = ir; t.rsp = rsp;
    t.e_rv = rv; t.e_addr = addr; t.e_iv = iv; t.e_pc = pc; t.e_busy = bsy;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; hlt = 1'b0; branch = 1'b0; branch_pc = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; instr_ready = 1'b0;
    w_reset = 1'b1; w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0;

    //  rst hlt br bpc      rr ir rsp | rv addr      iv pc       busy
    v(1, 0, 0, 0,        0, 0, 0,   0, 0,        0, 0,       0);
    // sequential stream with 1-cycle memory
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h2000,   0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h2004,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h2008,   1, 'h2000,  1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h200C,   1, 'h2004,  1);
    v(0, 0, 0, 0,        0, 1, 1,   1, 'h2010,   1, 'h2008,  1);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h2010,   1, 'h200C,  0);
    v(0, 0, 0, 0,        0, 0, 0,   1, 'h2010,   0, 0,       0);
    // decoder stalled: credit rule caps issue at DEPTH
    v(1, 0, 0, 0,        0, 0, 0,   0, 0,        0, 0,       0);
    v(0, 0, 0, 0,        1, 0, 0,   1, 'h2000,   0, 0,       0);
    v(0, 0, 0, 0,        1, 0, 1,   1, 'h2004,   0, 0,       1);
    v(0, 0, 0, 0,        1, 0, 1,   1, 'h2008,   1, 'h2000,  1);
    v(0, 0, 0, 0,        1, 0, 1,   1, 'h200C,   1, 'h2000,  1);
    v(0, 0, 0, 0,        1, 0, 1,   0, 'h2010,   1, 'h2000,  1);
    v(0, 0, 0, 0,        1, 0, 0,   0, 'h2010,   1, 'h2000,  0);
    v(0, 0, 0, 0,        1, 1, 0,   0, 'h2010,   1, 'h2000,  0);
    v(0, 0, 0, 0,        1, 0, 0,   1, 'h2010,   1, 'h2004,  0);
    v(0, 0, 0, 0,        1, 0, 1,   0, 'h2014,   1, 'h2004,  1);
    v(0, 0, 0, 0,        1, 1, 0,   0, 'h2014,   1, 'h2004,  0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h2014,   1, 'h2008,  0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h2014,   1, 'h200C,  0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h2014,   1, 'h2010,  0);
    v(0, 0, 0, 0,        0, 0, 0,   1, 'h2014,   0, 0,       0);
    // branch with two requests in flight
    v(1, 0, 0, 0,        0, 0, 0,   0, 0,        0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h2000,   0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h2004,   0, 0,       1);
    v(0, 0, 1, 'h3003,   1, 1, 0,   0, 'h2008,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   0, 'h3000,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h3000,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h3004,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h3008,   1, 'h3000,  1);
    v(0, 0, 0, 0,        0, 1, 1,   1, 'h300C,   1, 'h3004,  1);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h300C,   1, 'h3008,  0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h300C,   0, 0,       0);
    // branch coinciding with the only response
    v(1, 0, 0, 0,        0, 0, 0,   0, 0,        0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h2000,   0, 0,       0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h2004,   0, 0,       1);
    v(0, 0, 1, 'h4000,   0, 1, 1,   0, 'h2004,   0, 0,       1);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h4000,   0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h4000,   0, 0,       0);
    v(0, 0, 0, 0,        0, 1, 1,   1, 'h4004,   0, 0,       1);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h4004,   1, 'h4000,  0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h4004,   0, 0,       0);
    // halt with one request outstanding
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h4004,   0, 0,       0);
    v(0, 1, 0, 0,        1, 1, 1,   0, 'h4008,   0, 0,       1);
    v(0, 1, 0, 0,        1, 1, 0,   0, 'h4008,   1, 'h4004,  0);
    v(0, 1, 0, 0,        1, 1, 0,   0, 'h4008,   0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h4008,   0, 0,       0);
    v(0, 0, 0, 0,        0, 1, 1,   1, 'h400C,   0, 0,       1);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h400C,   1, 'h4008,  0);
    // back-to-back branches, second one during a drop
    v(1, 0, 0, 0,        0, 0, 0,   0, 0,        0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h2000,   0, 0,       0);
    v(0, 0, 0, 0,        1, 1, 0,   1, 'h2004,   0, 0,       1);
    v(0, 0, 1, 'h5000,   1, 1, 0,   0, 'h2008,   0, 0,       1);
    v(0, 0, 1, 'h6000,   1, 1, 1,   0, 'h5000,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h6000,   0, 0,       1);
    v(0, 0, 0, 0,        1, 1, 1,   1, 'h6004,   0, 0,       1);
    v(0, 0, 0, 0,        0, 1, 1,   1, 'h6008,   1, 'h6000,  1);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h6008,   1, 'h6004,  0);
    v(0, 0, 0, 0,        0, 1, 0,   1, 'h6008,   0, 0,       0);
    // reset mid-stream with a request in flight and a queued entry
    v(0, 0, 0, 0,        1, 0, 0,   1, 'h6008,   0, 0,       0);
    v(0, 0, 0, 0,        1, 0, 1,   1, 'h600C,   0, 0,       1);
    v(1, 0, 0, 0,        1, 0, 0,   0, 0,        0, 0,       0);
    v(0, 0, 0, 0,        0, 0, 0,   1, 'h2000,   0, 0,       0);

    @(negedge clk);
    foreach (vq[i]) begin
      reset       = vq[i].rst;
      hlt         = vq[i].hlt;
      branch      = vq[i].br;
      branch_pc   = vq[i].bpc;
      req_ready   = vq[i].rr;
      instr_ready = vq[i].ir;
      resp_valid  = 1'b0;
      resp_data   = '0;
      if (vq[i].rsp) begin
        if (pend.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL row%0d mem_pending: got 0 requests expected >=1", i);
        end else begin
          resp_valid = 1'b1;
          resp_data  = mem_data(pend.pop_front());
        end
      end
      #1;
      chk($sformatf("row%0d req_valid", i), 64'(req_valid), 64'(vq[i].e_rv));
      chk($sformatf("row%0d instr_valid", i), 64'(instr_valid), 64'(vq[i].e_iv));
      if (!vq[i].rst) begin
        chk($sformatf("row%0d req_addr", i), req_addr, vq[i].e_addr);
        chk($sformatf("row%0d busy", i), 64'(busy), 64'(vq[i].e_busy));
        if (vq[i].e_iv) begin
          chk($sformatf("row%0d instr_pc", i), instr_pc, vq[i].e_pc);
          chk($sformatf("row%0d instr_out", i), 64'(instr_out), 64'(mem_data(vq[i].e_pc)));
        end
      end
      if (req_valid && req_ready) pend.push_back(req_addr);
      @(negedge clk);
      if (vq[i].rst) pend.delete();
    end

    // Wrap-around instance: RESET_PC at the top of the address space.
    reset = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; instr_ready = 1'b0; branch = 1'b0;
    @(negedge clk);
    w_reset = 1'b0; w_req_ready = 1'b1;
    #1;
    chk("wrap first req_valid", 64'(w_req_valid), 64'd1);
    chk("wrap first req_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap reset busy", 64'(w_busy), 64'd0);
    chk("wrap reset instr_valid", 64'(w_instr_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("wrap second req_valid", 64'(w_req_valid), 64'd1);
    chk("wrap second req_addr", w_req_addr, 64'h0);
    chk("wrap busy", 64'(w_busy), 64'd1);
    @(negedge clk);
    w_resp_valid = 1'b1; w_resp_data = mem_data(64'hFFFF_FFFF_FFFF_FFFC);
    #1;
    chk("wrap max outstanding req_valid", 64'(w_req_valid), 64'd0);
    chk("wrap third req_addr", w_req_addr, 64'h4);
    @(negedge clk);
    w_resp_data = mem_data(64'h0);
    #1;
    chk("wrap instr_valid", 64'(w_instr_valid), 64'd1);
    chk("wrap instr_pc", w_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap instr_out", 64'(w_instr_out), 64'(mem_data(64'hFFFF_FFFF_FFFF_FFFC)));
    @(negedge clk);
    w_resp_valid = 1'b0; w_reset = 1'b1;
    @(negedge clk);
    w_reset = 1'b0; w_req_ready = 1'b0;
    #1;
    chk("wrap midreset req_valid", 64'(w_req_valid), 64'd1);
    chk("wrap midreset req_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap midreset instr_valid", 64'(w_instr_valid), 64'd0);
    chk("wrap midreset busy", 64'(w_busy), 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
